// File: rtl/wb2axi_pkg.sv
// rtl/wb2axi_pkg.sv - shared types and helpers for the Wishbone-to-AXI4 master bridge
package wb2axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, DRAIN
    } state_e;

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

    function automatic logic resp_ok(input resp_e r);
        return (r == RESP_OKAY) || (r == RESP_EXOKAY);
    endfunction

endpackage

// File: rtl/wb2axi_if.sv
// rtl/wb2axi_if.sv - Wishbone classic and single-beat AXI4 bus bundles
interface wb2axi_wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    wbs_cyc_i;
    logic                    wbs_stb_i;
    logic                    wbs_we_i;
    logic [ADDR_WIDTH-1:0]   wbs_addr_i;
    logic [DATA_WIDTH-1:0]   wbs_wdata_i;
    logic [DATA_WIDTH/8-1:0] wbs_sel_i;
    logic [DATA_WIDTH-1:0]   wbs_rdata_o;
    logic                    wbs_ack_o;
    logic                    wbs_err_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_addr_i, wbs_wdata_i, wbs_sel_i,
        output wbs_rdata_o, wbs_ack_o, wbs_err_o
    );
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_addr_i, wbs_wdata_i, wbs_sel_i,
        input  wbs_rdata_o, wbs_ack_o, wbs_err_o
    );
endinterface

interface wb2axi_axi_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     m_aw_id;
    logic [ADDR_WIDTH-1:0]   m_aw_addr;
    logic [7:0]              m_aw_len;
    logic [2:0]              m_aw_size;
    logic [1:0]              m_aw_burst;
    logic                    m_aw_valid;
    logic                    m_aw_ready;
    logic [DATA_WIDTH-1:0]   m_w_data;
    logic [DATA_WIDTH/8-1:0] m_w_strb;
    logic                    m_w_last;
    logic                    m_w_valid;
    logic                    m_w_ready;
    logic [ID_WIDTH-1:0]     m_b_id;
    logic [1:0]              m_b_resp;
    logic                    m_b_valid;
    logic                    m_b_ready;
    logic [ID_WIDTH-1:0]     m_ar_id;
    logic [ADDR_WIDTH-1:0]   m_ar_addr;
    logic [7:0]              m_ar_len;
    logic [2:0]              m_ar_size;
    logic [1:0]              m_ar_burst;
    logic                    m_ar_valid;
    logic                    m_ar_ready;
    logic [ID_WIDTH-1:0]     m_r_id;
    logic [DATA_WIDTH-1:0]   m_r_data;
    logic [1:0]              m_r_resp;
    logic                    m_r_last;
    logic                    m_r_valid;
    logic                    m_r_ready;

    modport master (
        output m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_valid,
        output m_w_data, m_w_strb, m_w_last, m_w_valid, m_b_ready,
        output m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_valid, m_r_ready,
        input  m_aw_ready, m_w_ready, m_b_id, m_b_resp, m_b_valid,
        input  m_ar_ready, m_r_id, m_r_data, m_r_resp, m_r_last, m_r_valid
    );
    modport slave (
        input  m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_valid,
        input  m_w_data, m_w_strb, m_w_last, m_w_valid, m_b_ready,
        input  m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_valid, m_r_ready,
        output m_aw_ready, m_w_ready, m_b_id, m_b_resp, m_b_valid,
        output m_ar_ready, m_r_id, m_r_data, m_r_resp, m_r_last, m_r_valid
    );
endinterface

// File: rtl/wb2axi_wdog.sv
// rtl/wb2axi_wdog.sv - loadable down-counter that flags expiry while enabled
module wb2axi_wdog #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    assign expired = en && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/wb2axi_master.sv
// rtl/wb2axi_master.sv - Wishbone classic slave to single-beat AXI4 master bridge
// Optional response watchdog and DRAIN state: WB2AXI_TIMEOUT_EN
module wb2axi_master
    import wb2axi_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          ID_WIDTH       = 4,
    parameter int unsigned AXI_ID         = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    wb2axi_wb_if.slave   wb,
    wb2axi_axi_if.master axi
);
    localparam logic [2:0] AXI_SIZE = axi_size(DATA_WIDTH);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] sel_q, sel_d;
    logic                    we_q, we_d;
    logic                    abort_q, abort_d;
    logic                    aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                    b_ready_q, b_ready_d, ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
    resp_e                   resp_q, resp_d;
    logic [DATA_WIDTH-1:0]   rcap_q, rcap_d, rdata_q, rdata_d;
    logic                    ack_q, ack_d, err_q, err_d;
    logic                    deliver;
    logic                    wdog_expired;

    // A completion is only reported to a WB master that is still in its cycle.
    assign deliver = !abort_q && wb.wbs_cyc_i;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        we_d       = we_q;
        abort_d    = abort_q || (state_q != IDLE && !wb.wbs_cyc_i);
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        resp_d     = resp_q;
        rcap_d     = rcap_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb.wbs_cyc_i && wb.wbs_stb_i && !ack_q && !err_q) begin
                    addr_d  = wb.wbs_addr_i;
                    wdata_d = wb.wbs_wdata_i;
                    sel_d   = wb.wbs_sel_i;
                    we_d    = wb.wbs_we_i;
                    abort_d = 1'b0;
                    if (wb.wbs_we_i) begin
                        state_d    = WR_REQ;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                    end else begin
                        state_d    = RD_REQ;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (aw_valid_q && axi.m_aw_ready) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_valid_q && axi.m_w_ready) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    b_ready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (axi.m_b_valid) begin
                    resp_d    = resp_e'(axi.m_b_resp);
                    b_ready_d = 1'b0;
                    state_d   = DONE;
                end
`ifdef WB2AXI_TIMEOUT_EN
                else if (wdog_expired) begin
                    state_d = DRAIN;
                    err_d   = deliver;
                end
`endif
            end
            RD_REQ: begin
                if (axi.m_ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RD_RESP;
                end
            end
            RD_RESP: begin
                if (axi.m_r_valid) begin
                    rcap_d    = axi.m_r_data;
                    resp_d    = axi.m_r_last ? resp_e'(axi.m_r_resp) : RESP_SLVERR;
                    r_ready_d = 1'b0;
                    state_d   = DONE;
                end
`ifdef WB2AXI_TIMEOUT_EN
                else if (wdog_expired) begin
                    state_d = DRAIN;
                    err_d   = deliver;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                rdata_d = we_q ? '0 : rcap_q;
                ack_d   = deliver && resp_ok(resp_q);
                err_d   = deliver && !resp_ok(resp_q);
            end
`ifdef WB2AXI_TIMEOUT_EN
            DRAIN: begin
                // The late response is accepted and thrown away; WB already saw err.
                if (we_q ? axi.m_b_valid : axi.m_r_valid) begin
                    b_ready_d = 1'b0;
                    r_ready_d = 1'b0;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

`ifdef WB2AXI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic wdog_load, wdog_en;

    assign wdog_load = (state_d == WR_RESP && state_q != WR_RESP) ||
                       (state_d == RD_RESP && state_q != RD_RESP);
    assign wdog_en   = (state_q == WR_RESP) || (state_q == RD_RESP);

    wb2axi_wdog #(.WIDTH(TW)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .load     (wdog_load),
        .en       (wdog_en),
        .load_val (TW'(TIMEOUT_CYCLES - 1)),
        .expired  (wdog_expired)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign wdog_expired   = 1'b0;
`endif

    logic unused_ids;
    assign unused_ids = ^{axi.m_b_id, axi.m_r_id, wdog_expired};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            abort_q    <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            resp_q     <= RESP_OKAY;
            rcap_q     <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            abort_q    <= abort_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            resp_q     <= resp_d;
            rcap_q     <= rcap_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign axi.m_aw_id    = ID_WIDTH'(AXI_ID);
    assign axi.m_aw_addr  = addr_q;
    assign axi.m_aw_len   = 8'd0;
    assign axi.m_aw_size  = AXI_SIZE;
    assign axi.m_aw_burst = BURST_INCR;
    assign axi.m_aw_valid = aw_valid_q;
    assign axi.m_w_data   = wdata_q;
    assign axi.m_w_strb   = sel_q;
    assign axi.m_w_last   = 1'b1;
    assign axi.m_w_valid  = w_valid_q;
    assign axi.m_b_ready  = b_ready_q;
    assign axi.m_ar_id    = ID_WIDTH'(AXI_ID);
    assign axi.m_ar_addr  = addr_q;
    assign axi.m_ar_len   = 8'd0;
    assign axi.m_ar_size  = AXI_SIZE;
    assign axi.m_ar_burst = BURST_INCR;
    assign axi.m_ar_valid = ar_valid_q;
    assign axi.m_r_ready  = r_ready_q;

    assign wb.wbs_rdata_o = rdata_q;
    assign wb.wbs_ack_o   = ack_q;
    assign wb.wbs_err_o   = err_q;
endmodule

// File: tb/tb_wb2axi_master.sv
// tb/tb_wb2axi_master.sv - directed self-checking bench for wb2axi_master
module tb_wb2axi_master;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat;
    logic seen_b, seen_ae, seen_ar;

    always #5 clk = ~clk;

    wb2axi_wb_if  #(.ADDR_WIDTH(32), .DATA_WIDTH(32))                wb ();
    wb2axi_axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi ();

    wb2axi_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .AXI_ID(0), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb),
        .axi (axi)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wb_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel);
        wb.wbs_cyc_i   = 1'b1;
        wb.wbs_stb_i   = 1'b1;
        wb.wbs_we_i    = we;
        wb.wbs_addr_i  = addr;
        wb.wbs_wdata_i = data;
        wb.wbs_sel_i   = sel;
    endtask

    task automatic wb_release();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!(wb.wbs_ack_o || wb.wbs_err_o) && n < 60) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1;
        wb_release();
        wb.wbs_addr_i = '0; wb.wbs_wdata_i = '0; wb.wbs_sel_i = '0;
        axi.m_aw_ready = 0; axi.m_w_ready = 0; axi.m_b_valid = 0; axi.m_b_resp = 0; axi.m_b_id = 0;
        axi.m_ar_ready = 0; axi.m_r_valid = 0; axi.m_r_resp = 0; axi.m_r_last = 1;
        axi.m_r_id = 0; axi.m_r_data = '0;
        repeat (3) tick();
        chk("rst_ack", wb.wbs_ack_o, 0);
        chk("rst_err", wb.wbs_err_o, 0);
        chk("rst_rdata", wb.wbs_rdata_o, 0);
        chk("rst_aw_valid", axi.m_aw_valid, 0);
        chk("rst_w_valid", axi.m_w_valid, 0);
        chk("rst_ar_valid", axi.m_ar_valid, 0);
        chk("rst_b_ready", axi.m_b_ready, 0);
        chk("rst_r_ready", axi.m_r_ready, 0);
        rst = 1'b0;
        tick();

        // zero-wait write
        axi.m_aw_ready = 1; axi.m_w_ready = 1; axi.m_b_valid = 1; axi.m_b_resp = 2'b00;
        wb_req(1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
        tick();
        chk("w1_aw_valid", axi.m_aw_valid, 1);
        chk("w1_w_valid", axi.m_w_valid, 1);
        chk("w1_aw_addr", axi.m_aw_addr, 32'h1000_0010);
        chk("w1_aw_len", axi.m_aw_len, 0);
        chk("w1_aw_size", axi.m_aw_size, 2);
        chk("w1_aw_burst", axi.m_aw_burst, 1);
        chk("w1_aw_id", axi.m_aw_id, 0);
        chk("w1_w_data", axi.m_w_data, 32'hDEAD_BEEF);
        chk("w1_w_strb", axi.m_w_strb, 4'hF);
        chk("w1_w_last", axi.m_w_last, 1);
        wait_done(lat);
        chk("w1_latency", lat + 1, 4);
        chk("w1_ack", wb.wbs_ack_o, 1);
        chk("w1_err", wb.wbs_err_o, 0);
        chk("w1_rdata", wb.wbs_rdata_o, 0);
        wb_release();
        tick();
        chk("w1_ack_once", wb.wbs_ack_o, 0);

        // write with w_ready delayed 5 cycles
        axi.m_w_ready = 0;
        wb_req(1, 32'h1000_0020, 32'hA5A5_0F0F, 4'h3);
        tick();
        chk("w2_strb", axi.m_w_strb, 4'h3);
        for (int i = 1; i <= 6; i++) begin
            chk("w2_w_valid", axi.m_w_valid, 1);
            chk("w2_w_data", axi.m_w_data, 32'hA5A5_0F0F);
            chk("w2_aw_valid", axi.m_aw_valid, (i == 1) ? 1 : 0);
            if (i == 6) axi.m_w_ready = 1;
            tick();
        end
        chk("w2_w_dropped", axi.m_w_valid, 0);
        wait_done(lat);
        chk("w2_latency", lat + 7, 9);
        chk("w2_ack", wb.wbs_ack_o, 1);
        wb_release();
        tick();
        chk("w2_ack_once", wb.wbs_ack_o, 0);

        // read with 3-cycle ar_ready stall
        axi.m_ar_ready = 0; axi.m_r_valid = 1; axi.m_r_data = 32'h1234_5678;
        axi.m_r_resp = 2'b00; axi.m_r_last = 1;
        wb_req(0, 32'h2000_0004, 32'h0, 4'hF);
        tick();
        chk("r1_ar_addr", axi.m_ar_addr, 32'h2000_0004);
        chk("r1_ar_len", axi.m_ar_len, 0);
        chk("r1_ar_size", axi.m_ar_size, 2);
        chk("r1_ar_burst", axi.m_ar_burst, 1);
        chk("r1_r_ready_early", axi.m_r_ready, 0);
        for (int i = 1; i <= 4; i++) begin
            chk("r1_ar_valid", axi.m_ar_valid, 1);
            if (i == 4) axi.m_ar_ready = 1;
            tick();
        end
        chk("r1_ar_dropped", axi.m_ar_valid, 0);
        chk("r1_r_ready", axi.m_r_ready, 1);
        wait_done(lat);
        chk("r1_latency", lat + 5, 7);
        chk("r1_ack", wb.wbs_ack_o, 1);
        chk("r1_rdata", wb.wbs_rdata_o, 32'h1234_5678);
        wb_release();
        tick();

        // read DECERR
        axi.m_r_resp = 2'b11; axi.m_r_data = 32'hCAFE_0001;
        wb_req(0, 32'h2000_0008, 32'h0, 4'hF);
        wait_done(lat);
        chk("r2_latency", lat, 4);
        chk("r2_ack", wb.wbs_ack_o, 0);
        chk("r2_err", wb.wbs_err_o, 1);
        wb_release();
        tick();

        // write SLVERR
        axi.m_b_resp = 2'b10;
        wb_req(1, 32'h1000_0040, 32'h0000_0001, 4'h1);
        wait_done(lat);
        chk("w3_latency", lat, 4);
        chk("w3_ack", wb.wbs_ack_o, 0);
        chk("w3_err", wb.wbs_err_o, 1);
        wb_release();
        tick();

        // read OKAY but r_last low is reported as an error
        axi.m_r_resp = 2'b00; axi.m_r_last = 0;
        wb_req(0, 32'h2000_000C, 32'h0, 4'hF);
        wait_done(lat);
        chk("r3_ack", wb.wbs_ack_o, 0);
        chk("r3_err", wb.wbs_err_o, 1);
        axi.m_r_last = 1;
        wb_release();
        tick();

        // write EXOKAY acks; stb held through ack is not re-accepted
        axi.m_b_resp = 2'b01;
        wb_req(1, 32'h1000_0050, 32'h5555_AAAA, 4'hF);
        wait_done(lat);
        chk("w4_ack", wb.wbs_ack_o, 1);
        chk("w4_err", wb.wbs_err_o, 0);
        tick();
        chk("w4_no_reaccept", axi.m_aw_valid, 0);
        wb_release();
        tick();

        // WB abort during a stalled write
        axi.m_aw_ready = 0; axi.m_w_ready = 0; axi.m_b_valid = 0; axi.m_b_resp = 2'b00;
        wb_req(1, 32'h1000_0030, 32'h1111_2222, 4'hF);
        tick();
        wb_release();
        chk("ab_aw_valid0", axi.m_aw_valid, 1);
        tick();
        chk("ab_aw_held", axi.m_aw_valid, 1);
        chk("ab_w_held", axi.m_w_valid, 1);
        axi.m_aw_ready = 1; axi.m_w_ready = 1; axi.m_b_valid = 1;
        seen_b = 0; seen_ae = 0;
        repeat (8) begin
            tick();
            seen_b  = seen_b | axi.m_b_ready;
            seen_ae = seen_ae | wb.wbs_ack_o | wb.wbs_err_o;
        end
        chk("ab_b_handshake", seen_b, 1);
        chk("ab_no_ack_err", seen_ae, 0);
        chk("ab_aw_done", axi.m_aw_valid, 0);
        axi.m_ar_ready = 1; axi.m_r_resp = 2'b00; axi.m_r_data = 32'h0BAD_F00D;
        wb_req(0, 32'h2000_0010, 32'h0, 4'hF);
        wait_done(lat);
        chk("ab_next_latency", lat, 4);
        chk("ab_next_ack", wb.wbs_ack_o, 1);
        chk("ab_next_rdata", wb.wbs_rdata_o, 32'h0BAD_F00D);
        wb_release();
        tick();

`ifdef WB2AXI_TIMEOUT_EN
        // response watchdog with TIMEOUT_CYCLES=16
        axi.m_b_valid = 0;
        wb_req(1, 32'h1000_0060, 32'h7777_8888, 4'hF);
        wait_done(lat);
        chk("to_latency", lat, 18);
        chk("to_err", wb.wbs_err_o, 1);
        chk("to_ack", wb.wbs_ack_o, 0);
        wb_release();
        tick();
        axi.m_r_data = 32'h0000_4242;
        wb_req(0, 32'h2000_0020, 32'h0, 4'hF);
        seen_ar = 0;
        repeat (20) begin
            tick();
            seen_ar = seen_ar | axi.m_ar_valid | wb.wbs_ack_o;
        end
        chk("to_stalled", seen_ar, 0);
        chk("to_drain_b_ready", axi.m_b_ready, 1);
        axi.m_b_valid = 1;
        wait_done(lat);
        chk("to_served_ack", wb.wbs_ack_o, 1);
        chk("to_served_rdata", wb.wbs_rdata_o, 32'h0000_4242);
        wb_release();
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb2axi_master.md
Name: wb2axi_master

Overview:
Wishbone classic slave to AXI4 master bridge, single-beat only; the opposite direction of the peripheral-side AXI-to-WB bridge.
Lets a Wishbone master (test-io port, peripheral DMA) issue reads and writes into the chip AXI fabric.
One outstanding transaction at a time. The WB cycle is held until the AXI response returns.

Parameters:
ADDR_WIDTH, 32, WB and AXI address width
DATA_WIDTH, 32, WB and AXI data width (32 or 64)
ID_WIDTH, 4, AXI ID width
AXI_ID, 0, constant ID driven on aw_id/ar_id
TIMEOUT_CYCLES, 1024, response watchdog limit (used only with the optional feature)

Ports:
clk  in  1  single clock
rst  in  1  synchronous active-high reset
wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1 each  WB cycle, strobe, write-enable
wbs_addr_i  in  ADDR_WIDTH  byte address
wbs_wdata_i  in  DATA_WIDTH  write data
wbs_sel_i  in  DATA_WIDTH/8  byte selects
wbs_rdata_o  out  DATA_WIDTH  read data, valid with ack
wbs_ack_o / wbs_err_o  out  1 each  one-cycle completion pulses
m_aw_id/addr/len/size/burst/valid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1  write address channel
m_aw_ready  in  1  write address ready
m_w_data/strb/last/valid  out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
m_w_ready  in  1  write data ready
m_b_id/resp/valid  in  ID_WIDTH/2/1  write response channel
m_b_ready  out  1  write response ready
m_ar_id/addr/len/size/burst/valid  out  as AW  read address channel
m_ar_ready  in  1  read address ready
m_r_id/data/resp/last/valid  in  ID_WIDTH/DATA_WIDTH/2/1/1  read data channel
m_r_ready  out  1  read data ready

Behaviour:
- Reset (synchronous, active-high): state IDLE; all valid/ready/ack/err outputs 0; wbs_rdata_o 0; address/data registers 0. Reset mid-transaction abandons the transaction; the fabric is reset on the same rst.
- Constant AXI fields: len=0, burst=INCR (2'b01), size=log2(DATA_WIDTH/8), w_last=1, aw_id=ar_id=AXI_ID. Address is passed unaligned-as-is.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: on cyc&stb, latch addr, wdata, sel, we. Go to WR_REQ (we=1) or RD_REQ (we=0).
- WR_REQ: aw_valid and w_valid are asserted together on the first cycle.
  - Each valid drops independently on its own handshake; flags aw_done and w_done record the handshake.
  - Once both are done, go to WR_RESP. The minimum case, both accepted in the first cycle, takes 1 cycle.
- WR_RESP: b_ready=1. On b_valid, capture resp and go to DONE.
- RD_REQ: ar_valid=1 until ar_ready, then go to RD_RESP.
- RD_RESP: r_ready=1. On r_valid, capture data and resp (r_last=0 is forced to SLVERR), then go to DONE.
- DONE (one cycle):
  - Pulse ack if resp is OKAY or EXOKAY, otherwise pulse err.
  - wbs_rdata_o holds the captured read data; it is 0 for writes.
  - Return to IDLE. A request is never re-accepted in the same cycle as ack.
- Minimum latency with zero-wait AXI, stb to ack: write 4 cycles, read 4 cycles.
- WB abort: if cyc drops in any non-IDLE state, the AXI transaction still completes (valids are never withdrawn before handshake). The DONE pulse is suppressed for that transaction.
- Valids and their payload are stable until handshake. Ready is never asserted outside the response states.
- Mismatched b_id/r_id values are ignored.

Optional Feature:
WB2AXI_TIMEOUT_EN:
- With the macro defined:
  - A counter runs only in WR_RESP and RD_RESP.
  - When the count reaches TIMEOUT_CYCLES, wbs_err_o pulses and the FSM enters DRAIN.
  - DRAIN holds b_ready/r_ready high until the late response arrives, discards it, then returns to IDLE. New requests wait in the meantime.
- Without the macro: no counter and no DRAIN state; the bridge waits indefinitely.

Decomposition:
- Package wb2axi_pkg holds:
  - resp enum: OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11
  - BURST_INCR constant
  - FSM state enum, including DRAIN
- One sub-module: wb2axi_wdog (loadable down-counter with expiry flag), instantiated only under WB2AXI_TIMEOUT_EN.

Test Plan:
- Write addr 0x1000_0010, data 0xDEADBEEF, sel 0xF; aw_ready/w_ready/b_valid all immediate, b_resp=OKAY -> aw/w fields match, strb 0xF, ack 1 cycle at 4 cycles, err 0.
- Write with w_ready delayed 5 cycles and aw_ready immediate -> aw_valid drops after 1 cycle, w_valid held 6 cycles with stable data, single ack.
- Read addr 0x2000_0004 with r_data 0x12345678, resp OKAY, 3-cycle ar_ready stall -> wbs_rdata_o=0x12345678 coincident with ack; ar_len=0, ar_size=2.
- Read with r_resp=DECERR; then a write with b_resp=SLVERR -> err pulse, no ack, in each case.
- cyc deasserted 1 cycle after write start -> AXI write completes fully, no ack/err, next request accepted normally.
- (WB2AXI_TIMEOUT_EN, TIMEOUT_CYCLES=16) b_valid withheld 40 cycles -> err at 16 cycles; a new request is stalled until the late b handshake, then served.
